// File: rtl/perceptron_pkg.sv
// -----------------------------------------------------------------------------
// perceptron_pkg
//
// Definitions shared by the perceptron network blocks:
//   - wb_state_e          : weight/bias loader FSM state encoding
//   - LAYER0 / LAYER1     : register-file layer select values
//   - calc_l0_cnt()       : number of parameter words for layer 0
//   - calc_l1_cnt()       : number of parameter words for layer 1
//   - calc_addr_w()       : word-index width that covers the larger layer
// -----------------------------------------------------------------------------
package perceptron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD0 = 2'd1,
        ST_LOAD1 = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

    localparam logic LAYER0 = 1'b0;
    localparam logic LAYER1 = 1'b1;

    // Layer 0: one weight per (hidden neuron, input) pair plus one bias per
    // hidden neuron.
    function automatic int calc_l0_cnt(input int n_in, input int n_hid);
        return n_in * n_hid + n_hid;
    endfunction

    // Layer 1: one weight per (output neuron, hidden neuron) pair plus one
    // bias per output neuron.
    function automatic int calc_l1_cnt(input int n_hid, input int n_out);
        return n_hid * n_out + n_out;
    endfunction

    // Index width for the larger of the two layers. Clamped to 1 so that a
    // degenerate one-word layer still yields a legal vector width.
    function automatic int calc_addr_w(input int l0_cnt, input int l1_cnt);
        int max_cnt;
        int w;
        max_cnt = (l0_cnt > l1_cnt) ? l0_cnt : l1_cnt;
        w       = $clog2(max_cnt);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : perceptron_pkg

// File: rtl/perceptron_wb_loader.sv
// -----------------------------------------------------------------------------
// perceptron_wb_loader
//
// Streams weight and bias words for the perceptron network from a serial
// configuration interface into the parameter register file. Layer-0 words
// are loaded first, then layer-1 words, then done_o pulses for one cycle and
// loaded_o is set until the next load begins.
//
// Within a layer, words arrive weights first in row-major order
// (neuron*fan_in + input), followed by the biases (fan_in*n_neurons + neuron).
// The loader does not reorder anything: the word index within the layer is
// the register-file address.
//
// Parameters:
//   DATA_W  width of one weight/bias word
//   N_IN    network inputs
//   N_HID   hidden neurons
//   N_OUT   output neurons
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous active-high reset; aborts a load in progress
//   load_start_i  single-cycle request to begin a full load (honoured in IDLE)
//   cfg_data_i    configuration word
//   cfg_val_i     cfg_data_i is valid
//   cfg_rdy_o     loader accepts a word this cycle
//   W1W0b_en_o    bit0: layer-0 load active, bit1: layer-1 load active
//   wr_en_o       register-file write strobe (one cycle after each accept)
//   wr_layer_o    0 = layer-0 storage, 1 = layer-1 storage
//   wr_addr_o     word index within the layer
//   wr_data_o     write data
//   done_o        one-cycle pulse when the load completes
//   loaded_o      sticky flag: all parameters are valid
// -----------------------------------------------------------------------------
module perceptron_wb_loader
    import perceptron_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_IN   = 2,
    parameter int N_HID  = 2,
    parameter int N_OUT  = 1,
    localparam int L0_CNT = calc_l0_cnt(N_IN, N_HID),
    localparam int L1_CNT = calc_l1_cnt(N_HID, N_OUT),
    localparam int ADDR_W = calc_addr_w(L0_CNT, L1_CNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    input  logic              cfg_val_i,
    output logic              cfg_rdy_o,
    output logic [1:0]        W1W0b_en_o,
    output logic              wr_en_o,
    output logic              wr_layer_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              done_o,
    output logic              loaded_o
);

    // Last word index of each layer, sized to the counter.
    localparam logic [ADDR_W-1:0] L0_LAST = ADDR_W'(L0_CNT - 1);
    localparam logic [ADDR_W-1:0] L1_LAST = ADDR_W'(L1_CNT - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    wb_state_e         state_reg;
    wb_state_e         state_next;
    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] cnt_next;

    logic              wr_en_reg;
    logic              wr_layer_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic              loaded_reg;

    // Decoded per-cycle controls
    logic              accept;      // word handshake completes this cycle
    logic              start_load;  // load request honoured this cycle
    logic              rdy_comb;
    logic [1:0]        en_comb;
    logic              done_comb;

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        start_load = 1'b0;
        rdy_comb   = 1'b0;
        en_comb    = 2'b00;
        done_comb  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (load_start_i) begin
                    start_load = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_LOAD0;
                end
            end

            ST_LOAD0: begin
                rdy_comb = 1'b1;
                en_comb  = 2'b01;
                accept   = cfg_val_i;
                if (accept) begin
                    if (cnt_reg == L0_LAST) begin
                        // Counter wraps only at the layer boundary.
                        cnt_next   = '0;
                        state_next = ST_LOAD1;
                    end else begin
                        cnt_next = cnt_reg + ADDR_W'(1);
                    end
                end
            end

            ST_LOAD1: begin
                rdy_comb = 1'b1;
                en_comb  = 2'b10;
                accept   = cfg_val_i;
                if (accept) begin
                    if (cnt_reg == L1_LAST) begin
                        cnt_next   = '0;
                        state_next = ST_DONE;
                    end else begin
                        cnt_next = cnt_reg + ADDR_W'(1);
                    end
                end
            end

            ST_DONE: begin
                // Keep layer-1 masked: the last layer-1 write lands in this
                // cycle, so the downstream pipeline must still be held.
                en_comb    = 2'b10;
                done_comb  = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential state, registered write port and loaded flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            wr_en_reg    <= 1'b0;
            wr_layer_reg <= LAYER0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            loaded_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;

            // Strobe is high only in the cycle after an accept; the payload
            // fields simply hold when there is nothing to write.
            wr_en_reg <= accept;
            if (accept) begin
                wr_layer_reg <= (state_reg == ST_LOAD1) ? LAYER1 : LAYER0;
                wr_addr_reg  <= cnt_reg;
                wr_data_reg  <= cfg_data_i;
            end

            if (start_load) begin
                loaded_reg <= 1'b0;
            end else if (state_reg == ST_DONE) begin
                loaded_reg <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cfg_rdy_o  = rdy_comb;
    assign W1W0b_en_o = en_comb;
    assign done_o     = done_comb;
    assign wr_en_o    = wr_en_reg;
    assign wr_layer_o = wr_layer_reg;
    assign wr_addr_o  = wr_addr_reg;
    assign wr_data_o  = wr_data_reg;
    assign loaded_o   = loaded_reg;

endmodule : perceptron_wb_loader

// File: tb/tb_perceptron_wb_loader.sv
// -----------------------------------------------------------------------------
// tb_perceptron_wb_loader
//
// Directed scenarios plus randomized loads for perceptron_wb_loader with
// default parameters (6 layer-0 words, 3 layer-1 words). A reference model
// tracks the load as "words accepted so far out of 9" and derives the
// expected layer/address of each write from that ordinal.
// -----------------------------------------------------------------------------
module tb_perceptron_wb_loader;

    localparam int L0    = 6;
    localparam int L1    = 3;
    localparam int TOTAL = L0 + L1;

    logic       clk;
    logic       reset;
    logic       load_start_i;
    logic [7:0] cfg_data_i;
    logic       cfg_val_i;
    logic       cfg_rdy_o;
    logic [1:0] W1W0b_en_o;
    logic       wr_en_o;
    logic       wr_layer_o;
    logic [2:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic       done_o;
    logic       loaded_o;

    perceptron_wb_loader dut (
        .clk          (clk),
        .reset        (reset),
        .load_start_i (load_start_i),
        .cfg_data_i   (cfg_data_i),
        .cfg_val_i    (cfg_val_i),
        .cfg_rdy_o    (cfg_rdy_o),
        .W1W0b_en_o   (W1W0b_en_o),
        .wr_en_o      (wr_en_o),
        .wr_layer_o   (wr_layer_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .done_o       (done_o),
        .loaded_o     (loaded_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = idle, 1 = loading, 2 = done cycle.
    int         m_phase;
    int         m_words;
    logic       m_loaded;
    logic       m_wen;
    logic       m_wl;
    logic [2:0] m_wa;
    logic [7:0] m_wd;

    // Per-scenario observations
    int cyc;
    int done_at;
    int n_wr;
    int n_done;
    int n_en01;
    int n_en10;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        cyc     = 0;
        done_at = 0;
        n_wr    = 0;
        n_done  = 0;
        n_en01  = 0;
        n_en10  = 0;
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // advance the model, then cross the rising edge.
    task automatic step(input logic st, input logic v, input logic [7:0] d, input logic r);
        logic [1:0] exp_en;
        load_start_i = st;
        cfg_val_i    = v;
        cfg_data_i   = d;
        reset        = r;
        #1;
        if (st && !r && m_phase == 0) cyc = 1;
        else cyc++;

        exp_en = (m_phase == 0) ? 2'b00 :
                 (m_phase == 2) ? 2'b10 :
                 (m_words < L0) ? 2'b01 : 2'b10;

        check("cfg_rdy", 32'(cfg_rdy_o), 32'(m_phase == 1));
        check("w1w0b_en", 32'(W1W0b_en_o), 32'(exp_en));
        check("done", 32'(done_o), 32'(m_phase == 2));
        check("loaded", 32'(loaded_o), 32'(m_loaded));
        check("wr_en", 32'(wr_en_o), 32'(m_wen));
        if (m_wen) begin
            check("wr_layer", 32'(wr_layer_o), 32'(m_wl));
            check("wr_addr", 32'(wr_addr_o), 32'(m_wa));
            check("wr_data", 32'(wr_data_o), 32'(m_wd));
        end

        if (done_o) begin
            done_at = cyc;
            n_done++;
        end
        if (wr_en_o) n_wr++;
        if (W1W0b_en_o == 2'b01) n_en01++;
        if (W1W0b_en_o == 2'b10) n_en10++;

        $display("t=%0t cyc=%0d st=%0b val=%0b data=%02h rst=%0b | rdy=%0b en=%02b wr=%0b L%0b a=%0d d=%02h done=%0b loaded=%0b",
                 $time, cyc, st, v, d, r, cfg_rdy_o, W1W0b_en_o, wr_en_o, wr_layer_o,
                 wr_addr_o, wr_data_o, done_o, loaded_o);

        // Model update from this cycle's inputs
        if (r) begin
            m_phase  = 0;
            m_words  = 0;
            m_loaded = 1'b0;
            m_wen    = 1'b0;
            m_wl     = 1'b0;
            m_wa     = '0;
            m_wd     = '0;
        end else begin
            m_wen = 1'b0;
            case (m_phase)
                0: if (st) begin
                    m_phase  = 1;
                    m_words  = 0;
                    m_loaded = 1'b0;
                end
                1: if (v) begin
                    m_wen = 1'b1;
                    m_wl  = (m_words >= L0);
                    m_wa  = 3'((m_words >= L0) ? (m_words - L0) : m_words);
                    m_wd  = d;
                    m_words++;
                    if (m_words == TOTAL) m_phase = 2;
                end
                default: begin
                    m_phase  = 0;
                    m_loaded = 1'b1;
                end
            endcase
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    // Full load with random valid gaps and random (ignored) start pulses.
    // Bounded: a load that never completes shows up as a wrong done count.
    task automatic random_load(input string tag);
        clear_counts();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 200; k++) begin
            if (n_done == 1 && m_phase == 0) break;
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), 1'b0);
        end
        check({tag, "_writes"}, 32'(n_wr), 32'(TOTAL));
        check({tag, "_dones"}, 32'(n_done), 32'd1);
        check({tag, "_loaded"}, 32'(loaded_o), 32'd1);
    endtask

    initial begin
        load_start_i = 1'b0;
        cfg_val_i    = 1'b0;
        cfg_data_i   = 8'h00;
        reset        = 1'b1;
        m_phase      = 0;
        m_words      = 0;
        m_loaded     = 1'b0;
        m_wen        = 1'b0;
        m_wl         = 1'b0;
        m_wa         = '0;
        m_wd         = '0;
        clear_counts();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset values of the payload fields (not covered by step()).
        check("rst_wr_layer", 32'(wr_layer_o), 32'd0);
        check("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        check("rst_wr_data", 32'(wr_data_o), 32'd0);

        // Idle: valid words without a start are never accepted.
        clear_counts();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
        check("idle_writes", 32'(n_wr), 32'd0);

        // Basic back-to-back load of 0x01..0x09.
        clear_counts();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 1; k <= TOTAL; k++) step(1'b0, 1'b1, 8'(k), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("basic_done_cycle", 32'(done_at), 32'd11);
        check("basic_writes", 32'(n_wr), 32'(TOTAL));
        check("basic_en01_cycles", 32'(n_en01), 32'd6);
        check("basic_en10_cycles", 32'(n_en10), 32'd4);

        // Valid gaps: valid low on every other cycle, starting with a gap.
        clear_counts();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 2 * TOTAL + 2; k++)
            step(1'b0, 1'(k % 2), 8'($urandom), 1'b0);
        check("gap_done_cycle", 32'(done_at), 32'd20);
        check("gap_writes", 32'(n_wr), 32'(TOTAL));

        // Start while busy: second start alongside word 3 is ignored.
        clear_counts();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < TOTAL + 3; k++)
            step((k == 3), 1'b1, 8'($urandom), 1'b0);
        check("busy_writes", 32'(n_wr), 32'(TOTAL));
        check("busy_dones", 32'(n_done), 32'd1);
        check("busy_done_cycle", 32'(done_at), 32'd11);

        // Reset after the 7th accept, then a fresh load from layer0 addr 0.
        clear_counts();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
        step(1'b1, 1'b1, 8'($urandom), 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_mid_en", 32'(W1W0b_en_o), 32'd0);
        check("rst_mid_loaded", 32'(loaded_o), 32'd0);
        random_load("after_rst");

        // Reload after a completed load repeats the basic sequence.
        clear_counts();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("reload_loaded_drop", 32'(loaded_o), 32'd0);
        for (int k = 1; k <= TOTAL; k++) step(1'b0, 1'b1, 8'(k), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("reload_done_cycle", 32'(done_at), 32'd11);
        check("reload_writes", 32'(n_wr), 32'(TOTAL));

        // Randomized loads.
        for (int n = 0; n < 5; n++) random_load("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_perceptron_wb_loader
